// File: rtl/float_round_pipe_if.sv
// Handshake bundle for float_round_pipe: input beat (mantissa, exponent,
// sign, guard/sticky, exact-zero flag, rounding mode) with valid/ready, and
// the rounded output beat with valid/ready and status flags.
// The slave side is the rounding stage; the master side feeds and drains it.
interface float_round_pipe_if #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W-1:0] in_mant;
    logic [EXP_W-1:0]  in_exp;
    logic              in_sign;
    logic              in_r;
    logic              in_s;
    logic              in_zero;
    logic [1:0]        rnd_mode;

    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] out_mant;
    logic [EXP_W-1:0]  out_exp;
    logic              out_sign;
    logic              out_inexact;
    logic              out_overflow;

    modport master (
        output in_valid, in_mant, in_exp, in_sign, in_r, in_s, in_zero, rnd_mode,
        output out_ready,
        input  in_ready,
        input  out_valid, out_mant, out_exp, out_sign, out_inexact, out_overflow
    );

    modport slave (
        input  in_valid, in_mant, in_exp, in_sign, in_r, in_s, in_zero, rnd_mode,
        input  out_ready,
        output in_ready,
        output out_valid, out_mant, out_exp, out_sign, out_inexact, out_overflow
    );
endinterface

// File: rtl/float_round_pipe.sv
// Two-stage rounding pipeline for the floating-point adder datapath.
// S1 decides the round-up increment and adds it; S2 renormalises on
// carry-out, saturates exponent overflow to infinity and drives the outputs.
// Specials (all-ones exponent) and exact zeros bypass rounding.
// Optional macro FLOAT_ROUND_STATS_EN adds saturating 16-bit counters of
// rounded-up and overflowed output transfers.
module float_round_pipe #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    float_round_pipe_if.slave   bus
`ifdef FLOAT_ROUND_STATS_EN
    ,
    output logic [15:0]         stat_round_up,
    output logic [15:0]         stat_overflow
`endif
);

    localparam logic [1:0]       RNE     = 2'd0;
    localparam logic [1:0]       RTZ     = 2'd1;
    localparam logic [1:0]       RUP     = 2'd2;
    localparam logic [1:0]       RDN     = 2'd3;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    // Stage advance conditions
    logic s1_valid;
    logic s2_valid;
    logic s2_adv;
    logic s1_adv;

    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    // S1 next-state signals
    logic              is_special;
    logic              inc;
    logic [MANT_W:0]   s1_sum_d;
    logic [EXP_W-1:0]  s1_exp_d;
    logic              s1_sign_d;
    logic              s1_inexact_d;

    // S1 registers
    logic [MANT_W:0]   s1_sum;
    logic [EXP_W-1:0]  s1_exp;
    logic              s1_sign;
    logic              s1_inexact;
    logic              s1_special;

    // S2 next-state signals and registers
    logic [MANT_W-1:0] s2_mant_d;
    logic [EXP_W-1:0]  s2_exp_d;
    logic              s2_inexact_d;
    logic              s2_overflow_d;
    logic [MANT_W-1:0] s2_mant;
    logic [EXP_W-1:0]  s2_exp;
    logic              s2_sign;
    logic              s2_inexact;
    logic              s2_overflow;

`ifdef FLOAT_ROUND_STATS_EN
    logic              s1_inc;
    logic              s2_inc;
`endif

    assign is_special = (bus.in_exp == EXP_MAX);

    // S1: rounding decision, increment add, special/zero bypass
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        inc          = 1'b0;
        s1_sum_d     = {1'b0, bus.in_mant};
        s1_exp_d     = bus.in_exp;
        s1_sign_d    = bus.in_sign;
        s1_inexact_d = 1'b0;
        if (!is_special) begin
            if (bus.in_zero) begin
                // Exact cancellation gives -0 only when rounding toward -inf
                s1_sum_d  = '0;
                s1_exp_d  = '0;
                s1_sign_d = (bus.rnd_mode == RDN);
            end else begin
                case (bus.rnd_mode)
                    RNE: inc = bus.in_r && (bus.in_s || bus.in_mant[0]);
                    RTZ: inc = 1'b0;
                    RUP: inc = !bus.in_sign && (bus.in_r || bus.in_s);
                    RDN: inc = bus.in_sign && (bus.in_r || bus.in_s);
                endcase
                s1_sum_d     = {1'b0, bus.in_mant} + {{MANT_W{1'b0}}, inc};
                s1_inexact_d = bus.in_r || bus.in_s;
            end
        end
    end

    // S1 register: loads a new beat whenever the stage may advance
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            s1_valid   <= 1'b0;
            s1_sum     <= '0;
            s1_exp     <= '0;
            s1_sign    <= 1'b0;
            s1_inexact <= 1'b0;
            s1_special <= 1'b0;
`ifdef FLOAT_ROUND_STATS_EN
            s1_inc     <= 1'b0;
`endif
        end else if (s1_adv) begin
            // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sum     <= s1_sum_d;
                s1_exp     <= s1_exp_d;
                s1_sign    <= s1_sign_d;
                s1_inexact <= s1_inexact_d;
                s1_special <= is_special;
`ifdef FLOAT_ROUND_STATS_EN
                s1_inc     <= inc;
`endif
            end
        end
    end

    // S2: renormalise on carry-out and saturate to infinity on overflow
    always_comb begin
        s2_mant_d     = s1_sum[MANT_W-1:0];
        s2_exp_d      = s1_exp;
        s2_inexact_d  = s1_inexact;
        s2_overflow_d = 1'b0;
        if (!s1_special) begin
            if (s1_sum[MANT_W]) begin
                s2_mant_d = s1_sum[MANT_W:1];
                s2_exp_d  = s1_exp + EXP_W'(1);
            end
            if (s2_exp_d == EXP_MAX) begin
                s2_mant_d     = '0;
                s2_overflow_d = 1'b1;
                s2_inexact_d  = 1'b1;
            end
        end
    end

    // S2 register: output stage, holds while downstream stalls
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            s2_valid    <= 1'b0;
            s2_mant     <= '0;
            s2_exp      <= '0;
            s2_sign     <= 1'b0;
            s2_inexact  <= 1'b0;
            s2_overflow <= 1'b0;
`ifdef FLOAT_ROUND_STATS_EN
            s2_inc      <= 1'b0;
`endif
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_mant     <= s2_mant_d;
                s2_exp      <= s2_exp_d;
                s2_sign     <= s1_sign;
                s2_inexact  <= s2_inexact_d;
                s2_overflow <= s2_overflow_d;
`ifdef FLOAT_ROUND_STATS_EN
                s2_inc      <= s1_inc;
`endif
            end
        end
    end

    assign bus.out_valid    = s2_valid;
    assign bus.out_mant     = s2_mant;
    assign bus.out_exp      = s2_exp;
    assign bus.out_sign     = s2_sign;
    assign bus.out_inexact  = s2_inexact;
    assign bus.out_overflow = s2_overflow;

`ifdef FLOAT_ROUND_STATS_EN
    // Saturating counters of rounded-up and overflowed output transfers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            stat_round_up <= '0;
            stat_overflow <= '0;
        end else if (s2_valid && bus.out_ready) begin
            if (s2_inc && stat_round_up != 16'hFFFF) begin
                stat_round_up <= stat_round_up + 16'd1;
            end
            if (s2_overflow && stat_overflow != 16'hFFFF) begin
                stat_overflow <= stat_overflow + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_float_round_pipe.sv
// Self-checking bench for float_round_pipe: directed rounding cases,
// backpressure/capacity, randomised stream with random stalls, and reset
// flush. Expected beats are queued at input acceptance and compared at
// output transfer.
module tb_float_round_pipe;

    localparam int MW = 24;
    localparam int EW = 8;

    typedef struct packed {
        logic [15:0]   id;
        logic [MW-1:0] mant;
        logic [EW-1:0] exp;
        logic          sign;
        logic          inexact;
        logic          ovf;
        logic          inc;
    } exp_t;

    logic Clock;
    logic Reset;

    float_round_pipe_if #(.MANT_W(MW), .EXP_W(EW)) bus ();

`ifdef FLOAT_ROUND_STATS_EN
    logic [15:0] stat_round_up;
    logic [15:0] stat_overflow;
`endif

    float_round_pipe #(.MANT_W(MW), .EXP_W(EW)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .bus           (bus)
`ifdef FLOAT_ROUND_STATS_EN
        ,
        .stat_round_up (stat_round_up),
        .stat_overflow (stat_overflow)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    int   next_id  = 0;
    int   exp_up   = 0;
    int   exp_ovf  = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [MW-1:0] m, input logic [EW-1:0] e, input logic sg,
                                input logic inex, input logic ovf, input logic inc);
        exp_t x;
        x         = '0;
        x.mant    = m;
        x.exp     = e;
        x.sign    = sg;
        x.inexact = inex;
        x.ovf     = ovf;
        x.inc     = inc;
        return x;
    endfunction

    // Reference model: integer add of the increment, shift on carry
    function automatic exp_t model(input logic [MW-1:0] m, input logic [EW-1:0] e, input logic sg,
                                   input logic r, input logic s, input logic z, input logic [1:0] md);
        exp_t        x;
        logic        inc;
        int unsigned v;
        int unsigned ev;
        x = '0;
        if (e == 8'hFF) begin
            x.mant = m;
            x.exp  = e;
            x.sign = sg;
            return x;
        end
        if (z) begin
            x.sign = (md == 2'd3);
            return x;
        end
        case (md)
            2'd0:    inc = r && (s || m[0]);
            2'd1:    inc = 1'b0;
            2'd2:    inc = !sg && (r || s);
            default: inc = sg && (r || s);
        endcase
        v  = 32'(m) + 32'(inc);
        ev = 32'(e);
        if (v >= (32'd1 << MW)) begin
            v  = v >> 1;
            ev = ev + 1;
        end
        x.inc     = inc;
        x.sign    = sg;
        x.inexact = r || s;
        if (ev == 255) begin
            x.exp     = 8'hFF;
            x.ovf     = 1'b1;
            x.inexact = 1'b1;
        end else begin
            x.mant = v[MW-1:0];
            x.exp  = ev[EW-1:0];
        end
        return x;
    endfunction

    task automatic drive(input logic [MW-1:0] m, input logic [EW-1:0] e, input logic sg,
                         input logic r, input logic s, input logic z, input logic [1:0] md);
        bus.in_valid = 1'b1;
        bus.in_mant  = m;
        bus.in_exp   = e;
        bus.in_sign  = sg;
        bus.in_r     = r;
        bus.in_s     = s;
        bus.in_zero  = z;
        bus.rnd_mode = md;
    endtask

    // Present one beat, wait (bounded) for acceptance, queue its expectation
    task automatic send(input logic [MW-1:0] m, input logic [EW-1:0] e, input logic sg,
                        input logic r, input logic s, input logic z, input logic [1:0] md,
                        input exp_t want);
        logic acc;
        int   waited;
        exp_t w;
        acc    = 1'b0;
        waited = 0;
        w      = want;
        w.id   = 16'(next_id);
        next_id++;
        drive(m, e, sg, r, s, z, md);
        while (!acc && waited < 200) begin
            @(negedge Clock);
            acc = bus.in_ready;
            if (acc) sb.push_back(w);
            @(posedge Clock);
            #1;
            waited++;
        end
        if (!acc) check("send accept timeout", 64'(acc), 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited        = 0;
        bus.out_ready = 1'b1;
        while (sb.size() != 0 && waited < 100) begin
            @(posedge Clock);
            #1;
            waited++;
        end
        repeat (2) @(posedge Clock);
        #1;
        check("scoreboard drained", 64'(sb.size()), 64'd0);
    endtask

    // Output monitor: compares each transferred beat with the queue head
    always @(negedge Clock) begin
        exp_t e;
        if (!Reset && bus.out_valid && bus.out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                check("unexpected output beat", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check($sformatf("beat%0d mant", e.id), 64'(bus.out_mant), 64'(e.mant));
                check($sformatf("beat%0d exp", e.id), 64'(bus.out_exp), 64'(e.exp));
                check($sformatf("beat%0d sign", e.id), 64'(bus.out_sign), 64'(e.sign));
                check($sformatf("beat%0d inexact", e.id), 64'(bus.out_inexact), 64'(e.inexact));
                check($sformatf("beat%0d overflow", e.id), 64'(bus.out_overflow), 64'(e.ovf));
                if (e.inc) exp_up++;
                if (e.ovf) exp_ovf++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] snap;
        int          base;
        logic        rnd_done;

        Reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_mant   = '0;
        bus.in_exp    = '0;
        bus.in_sign   = 1'b0;
        bus.in_r      = 1'b0;
        bus.in_s      = 1'b0;
        bus.in_zero   = 1'b0;
        bus.rnd_mode  = 2'd0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset out_mant", 64'(bus.out_mant), 64'd0);
        check("reset out_exp", 64'(bus.out_exp), 64'd0);
        check("reset out_sign", 64'(bus.out_sign), 64'd0);
        check("reset out_inexact", 64'(bus.out_inexact), 64'd0);
        check("reset out_overflow", 64'(bus.out_overflow), 64'd0);
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge Clock);
        #1;
        Reset = 1'b0;

        // Latency: a single beat appears exactly two cycles after acceptance
        drive(24'h800001, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        @(negedge Clock);
        check("latency accept", 64'(bus.in_ready), 64'd1);
        sb.push_back(mk(24'h800001 + 24'd1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1));
        next_id++;
        @(posedge Clock);
        #1;
        bus.in_valid = 1'b0;
        @(negedge Clock);
        check("latency cycle1 out_valid", 64'(bus.out_valid), 64'd0);
        @(negedge Clock);
        check("latency cycle2 out_valid", 64'(bus.out_valid), 64'd1);
        @(posedge Clock);
        #1;

        // Directed rounding cases, streamed back to back
        send(24'h800002, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, mk(24'h800002, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0));
        send(24'h800002, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, mk(24'h800002, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0));
        send(24'hFFFFFF, 8'h7E, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, mk(24'h800000, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b1));
        send(24'hFFFFFF, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, mk(24'h000000, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1));
        send(24'hFFFFFF, 8'hFE, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, mk(24'hFFFFFF, 8'hFE, 1'b1, 1'b1, 1'b0, 1'b0));
        send(24'h123456, 8'h40, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, mk(24'h000000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        send(24'h123456, 8'h40, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, mk(24'h000000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        send(24'hC00000, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, mk(24'hC00000, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0));
        send(24'h800000, 8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, mk(24'h800001, 8'h10, 1'b1, 1'b1, 1'b0, 1'b1));
        send(24'h800000, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, mk(24'h800000, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0));
        send(24'hABCDEF, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, mk(24'hABCDEF, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0));
        drain();

        // Backpressure: two beats fill the pipe, the third is refused
        bus.out_ready = 1'b0;
        send(24'h900001, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, mk(24'h900001, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0));
        send(24'h900003, 8'h21, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, mk(24'h900004, 8'h21, 1'b0, 1'b1, 1'b0, 1'b1));
        drive(24'h900005, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3);
        @(negedge Clock);
        snap = 64'({bus.out_mant, bus.out_exp, bus.out_sign, bus.out_inexact, bus.out_overflow});
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall%0d in_ready", i), 64'(bus.in_ready), 64'd0);
            check($sformatf("stall%0d out_valid", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("stall%0d outputs stable", i),
                  64'({bus.out_mant, bus.out_exp, bus.out_sign, bus.out_inexact, bus.out_overflow}), snap);
            @(negedge Clock);
        end
        @(posedge Clock);
        #1;
        bus.out_ready = 1'b1;
        send(24'h900005, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, mk(24'h900006, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1));
        drain();

        // Random stream with random downstream stalls
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [MW-1:0] m;
                    logic [EW-1:0] e;
                    logic          sg, r, s, z;
                    logic [1:0]    md;
                    m  = MW'($urandom);
                    if ($urandom_range(0, 5) == 0) m = '1;
                    e  = EW'($urandom_range(0, 255));
                    if ($urandom_range(0, 5) == 0) e = 8'hFE;
                    sg = 1'($urandom_range(0, 1));
                    r  = 1'($urandom_range(0, 1));
                    s  = 1'($urandom_range(0, 1));
                    z  = ($urandom_range(0, 7) == 0);
                    md = 2'($urandom_range(0, 3));
                    send(m, e, sg, r, s, z, md, model(m, e, sg, r, s, z, md));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge Clock);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        // Reset with two beats in flight: flushed, nothing emitted afterwards
        bus.out_ready = 1'b0;
        send(24'hA00001, 8'h30, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, mk(24'hA00002, 8'h30, 1'b0, 1'b1, 1'b0, 1'b1));
        send(24'hA00003, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, mk(24'hA00003, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0));
        check("inflight out_valid", 64'(bus.out_valid), 64'd1);
        Reset = 1'b1;
        #1;
        check("mid reset out_valid", 64'(bus.out_valid), 64'd0);
        check("mid reset in_ready", 64'(bus.in_ready), 64'd1);
        sb.delete();
        exp_up  = 0;
        exp_ovf = 0;
        base    = n_out;
        repeat (2) @(posedge Clock);
        #1;
        Reset         = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) @(posedge Clock);
        #1;
        check("beats after reset", 64'(n_out - base), 64'd0);
        check("out_valid after reset", 64'(bus.out_valid), 64'd0);

        // One fresh beat after the flush still flows normally
        send(24'hFFFFFF, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, mk(24'h000000, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1));
        drain();

`ifdef FLOAT_ROUND_STATS_EN
        check("stat_round_up", 64'(stat_round_up), 64'(exp_up));
        check("stat_overflow", 64'(stat_overflow), 64'(exp_ovf));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/float_round_pipe.md
Name: float_round_pipe

Overview:
- Parametrised, pipelined rounding stage for the floating-point adder datapath.
- Sits after the normaliser and before result packing.
- Takes a normalised mantissa/exponent with guard (R) and sticky (S) bits and applies one of four IEEE-754 rounding modes.
- Renormalises on mantissa carry-out, saturates exponent overflow to infinity, and passes specials and exact zeros through.
- Uses a valid/ready handshake with full throughput and backpressure.

Parameters:
- MANT_W, 24, mantissa width including hidden bit (MSB = hidden bit for normal values).
- EXP_W, 8, biased exponent width; all-ones exponent encodes Inf/NaN.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_mant  in  MANT_W  normalised mantissa.
- in_exp  in  EXP_W  biased exponent.
- in_sign  in  1  result sign.
- in_r  in  1  guard/round bit.
- in_s  in  1  sticky bit.
- in_zero  in  1  exact zero result (cancellation).
- rnd_mode  in  2  0=RNE, 1=RTZ, 2=RUP (+inf), 3=RDN (-inf); sampled with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_mant  out  MANT_W  rounded mantissa.
- out_exp  out  EXP_W  rounded exponent.
- out_sign  out  1  rounded sign.
- out_inexact  out  1  R|S was set for a finite non-zero beat.
- out_overflow  out  1  rounding pushed the exponent to all-ones.

Behaviour:
- Reset (async, active-high): all stage registers cleared; out_valid=0; out_mant/out_exp/out_sign/out_inexact/out_overflow=0. in_ready=1 once the pipeline is empty. Reset mid-operation discards in-flight beats; none are emitted after release.
- Pipeline structure:
  - Two register stages: S1 (decision + add) and S2 (renormalise; S2 registers drive the outputs).
  - Latency: 2 cycles from input accept to out_valid.
  - Throughput: 1 beat per cycle.
- Handshake:
  - Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
  - S2 advances when !out_valid | out_ready. S1 advances when !s1_valid | S2 advances.
  - in_ready = !s1_valid | !out_valid | out_ready (combinational from out_ready; no combinational in_valid->out_valid path).
  - Outputs hold stable while out_valid & !out_ready.
  - Capacity is 2 beats: with out_ready=0, exactly two beats are accepted, then in_ready=0.
- S1 increment decision (inc):
  - RNE: R & (S | mant[0]).
  - RTZ: 0.
  - RUP: !sign & (R | S).
  - RDN: sign & (R | S).
- S1 sum: sum = {1'b0,in_mant} + inc, width MANT_W+1.
- S2 renormalisation:
  - If sum[MANT_W]=1: out_mant = sum[MANT_W:1] (i.e. 1 followed by zeros), out_exp = in_exp + 1.
  - Otherwise: out_mant = sum[MANT_W-1:0], out_exp = in_exp.
- Overflow: if the resulting exponent equals all-ones, out_mant=0, out_exp=all-ones (infinity, sign kept), out_overflow=1, out_inexact=1.
- Special input (in_exp all-ones): mantissa, exponent and sign passed unchanged; no increment; out_inexact=0, out_overflow=0.
- in_zero=1 (highest priority over rounding; the special check precedes it):
  - out_mant=0, out_exp=0, out_inexact=0.
  - out_sign = 1 if rnd_mode==RDN, else 0 (IEEE exact-cancellation sign).
- out_inexact = R|S for finite non-zero beats, regardless of whether an increment happened.

Optional Feature:
- Macro: FLOAT_ROUND_STATS_EN.
- When defined, two output ports are added:
  - stat_round_up (16 bit): counts output transfers where inc=1.
  - stat_overflow (16 bit): counts output transfers with out_overflow=1.
- Both counters saturate at 16'hFFFF, are cleared by Reset, and count only on out_valid & out_ready.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- RNE tie, odd LSB: mant=24'h800001, exp=8'h80, R=1, S=0, mode=0 -> 2 cycles later mant=24'h800002, exp=8'h80, inexact=1.
- RNE tie, even LSB: mant=24'h800002, R=1, S=0 -> mant=24'h800002, inexact=1. Same input with mode=1 (RTZ) and S=1 -> mant=24'h800002.
- Carry renormalise: mant=24'hFFFFFF, exp=8'h7E, R=1, S=1, mode=0 -> mant=24'h800000, exp=8'h7F, overflow=0.
- Overflow: mant=24'hFFFFFF, exp=8'hFE, sign=0, R=1, mode=2 -> exp=8'hFF, mant=0, overflow=1, inexact=1. Same input with sign=1, mode=2 -> mant=24'hFFFFFF, exp=8'hFE, overflow=0.
- Zero and special: in_zero=1, mode=3 -> mant=0, exp=0, sign=1. exp=8'hFF, mant=24'hC00000, R=1 -> passed unchanged, inexact=0.
- Backpressure and reset: out_ready=0, stream 3 beats -> only 2 accepted, then in_ready=0 and outputs stable. Raise out_ready -> beats emerge in order, no loss or duplication. Assert Reset while 2 beats are in flight -> out_valid=0 immediately; nothing emitted after release.
